// File: rtl/npc_sram_resp.sv
// npc_sram_resp: single-outstanding SRAM responder with programmable latency and valid/ready response
// Ports: clk, reset (async, active high);
//        req_valid/req_ready, req_wen, req_addr, req_wdata, req_wmask : request channel
//        rsp_valid/rsp_ready, rsp_rdata, rsp_err                      : response channel
// Optional: define NPC_SRAM_TRACE_EN to print one trace line per accepted request.
module npc_sram_resp #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h80000000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [31:0] mem [DEPTH];
    logic [31:0] off;
    logic [AW-1:0] idx;
    logic in_range;
    logic acc;
    logic [31:0] rd_nxt;
    // Unsigned offset wraps for addresses below BASE_ADDR, so the >= test is still needed.
    always_comb begin
        off      = req_addr - BASE_ADDR;
        idx      = off[AW+1:2];
        in_range = req_addr >= BASE_ADDR && (off >> 2) < 32'(DEPTH);
        acc      = req_valid && req_ready;
        rd_nxt   = (req_wen || !in_range) ? 32'd0 : mem[idx];
    end
    // Array has no reset; stores commit at the acceptance edge.
    always_ff @(posedge clk)
        if (acc && req_wen && in_range)
            for (int i = 0; i < 4; i++)
                if (req_wmask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    rsp_err   <= !in_range;
                    rsp_rdata <= rd_nxt;
                    if (LATENCY == 1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef NPC_SRAM_TRACE_EN
    always_ff @(posedge clk)
        if (acc) begin
            if (req_wen) $display("SRAM W addr=%h data=%h mask=%b err=%b", req_addr, req_wdata, req_wmask, !in_range);
            else $display("SRAM R addr=%h data=%h err=%b", req_addr, rd_nxt, !in_range);
        end
`endif
endmodule

// File: tb/tb_npc_sram_resp.sv
// tb_npc_sram_resp: table, directed and randomized checks of npc_sram_resp at LATENCY 2 and 1
module tb_npc_sram_resp;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic sel = 1'b0, rv = 1'b0, wen = 1'b0, rrdy = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0] wmask = '0;
    logic rv_a, rv_b, rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
    logic [31:0] rd_a, rd_b;
    logic rdy, vld, err;
    logic [31:0] rdata;
    assign rv_a  = rv & ~sel;
    assign rv_b  = rv & sel;
    assign rdy   = sel ? rdy_b : rdy_a;
    assign vld   = sel ? vld_b : vld_a;
    assign err   = sel ? err_b : err_a;
    assign rdata = sel ? rd_b : rd_a;
    npc_sram_resp #(.DEPTH(1024), .BASE_ADDR(32'h80000000), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(rdy_a), .req_wen(wen),
        .req_addr(addr), .req_wdata(wdata), .req_wmask(wmask), .rsp_valid(vld_a),
        .rsp_ready(rrdy), .rsp_rdata(rd_a), .rsp_err(err_a));
    npc_sram_resp #(.DEPTH(1024), .BASE_ADDR(32'h80000000), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(rdy_b), .req_wen(wen),
        .req_addr(addr), .req_wdata(wdata), .req_wmask(wmask), .rsp_valid(vld_b),
        .rsp_ready(rrdy), .rsp_rdata(rd_b), .rsp_err(err_b));
    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // Reference memory for the LATENCY=2 instance: word value plus which byte lanes are known.
    logic [31:0] mv [int];
    logic [3:0] mk [int];
    function automatic bit in_rng(input logic [31:0] a);
        return a >= 32'h80000000 && (a - 32'h80000000) < 32'd4096;
    endfunction
    function automatic int widx(input logic [31:0] a);
        return int'((a - 32'h80000000) / 4);
    endfunction
    function automatic void mdl_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int wi;
        if (!in_rng(a)) return;
        wi = widx(a);
        if (!mv.exists(wi)) begin
            mv[wi] = '0;
            mk[wi] = '0;
        end
        for (int i = 0; i < 4; i++)
            if (m[i]) mv[wi][8*i +: 8] = d[8*i +: 8];
        mk[wi] = mk[wi] | m;
    endfunction
    // One full transaction on the selected instance; returns response fields and acceptance-to-valid latency.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input int hold, output logic [31:0] rd, output logic e, output int lat);
        int n;
        @(negedge clk);
        rv = 1'b1; wen = w; addr = a; wdata = d; wmask = m;
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready still %b after %0d cycles", rdy, n);
        end
        @(posedge clk);
        @(negedge clk);
        rv = 1'b0; wen = 1'b0;
        lat = 1;
        while (!vld && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!vld) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid still %b after %0d cycles", vld, lat);
        end
        rd = rdata;
        e = err;
        repeat (hold) begin
            @(negedge clk);
            chk("resp_hold", {vld, rdy, e, rdata}, {1'b1, 1'b0, err, rd});
        end
        rrdy = 1'b1;
        @(negedge clk);
        rrdy = 1'b0;
        chk("post_handshake", {rdy, vld, err, rdata}, {1'b1, 1'b0, 1'b0, 32'd0});
    endtask
    typedef struct {
        logic w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0] m;
        logic [31:0] er;
        logic ee;
    } vec_t;
    localparam int NV = 17;
    vec_t tbl [NV];
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
        $fatal(1);
    end
    initial begin
        logic [31:0] rd, er, bm, a;
        logic e, ee, w;
        int lat, n;
        tbl[0]  = '{1'b1, 32'h80000010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h80000010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h80000010, 32'h000000AA, 4'h1, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 32'h80000010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0};
        tbl[4]  = '{1'b1, 32'h80000010, 32'h12340000, 4'hC, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 32'h80000010, 32'h0, 4'h0, 32'h1234BEAA, 1'b0};
        tbl[6]  = '{1'b1, 32'h80000000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 32'h7FFFFFFC, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[8]  = '{1'b0, 32'h80001000, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[9]  = '{1'b1, 32'h80001000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
        tbl[10] = '{1'b0, 32'h80000000, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0};
        tbl[11] = '{1'b1, 32'h80000014, 32'h11223344, 4'hF, 32'h0, 1'b0};
        tbl[12] = '{1'b1, 32'h80000016, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
        tbl[13] = '{1'b0, 32'h80000017, 32'h0, 4'h0, 32'h11223344, 1'b0};
        tbl[14] = '{1'b1, 32'h80000FFF, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0};
        tbl[15] = '{1'b0, 32'h80000FFC, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0};
        tbl[16] = '{1'b0, 32'h00000000, 32'h0, 4'h0, 32'h0, 1'b1};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_idle_l2", {rdy_a, vld_a, err_a, rd_a}, {1'b1, 1'b0, 1'b0, 32'd0});
            chk("reset_idle_l1", {rdy_b, vld_b, err_b, rd_b}, {1'b1, 1'b0, 1'b0, 32'd0});
        end
        for (int i = 0; i < NV; i++) begin
            txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m, i % 3, rd, e, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].er);
            chk($sformatf("vec%0d_err", i), e, tbl[i].ee);
            chk($sformatf("vec%0d_latency", i), lat, 2);
            if (tbl[i].w) mdl_store(tbl[i].a, tbl[i].d, tbl[i].m);
        end
        // Response held for 6 cycles while a second request waits on req_valid.
        @(negedge clk);
        rv = 1'b1; wen = 1'b0; addr = 32'h80000010;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h80000000;
        n = 1;
        while (!vld && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_first_latency", n, 2);
        chk("hold_first_rdata", rdata, 32'h1234BEAA);
        repeat (6) begin
            @(negedge clk);
            chk("hold_stable", {vld, rdy, err, rdata}, {1'b1, 1'b0, 1'b0, 32'h1234BEAA});
        end
        rrdy = 1'b1;
        @(negedge clk);
        rrdy = 1'b0;
        chk("hold_after_handshake", {rdy, vld}, {1'b1, 1'b0});
        @(negedge clk);
        rv = 1'b0;
        chk("hold_second_accepted", rdy, 1'b0);
        n = 1;
        while (!vld && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_second_latency", n, 2);
        chk("hold_second_rdata", rdata, 32'hCAFEF00D);
        rrdy = 1'b1;
        @(negedge clk);
        rrdy = 1'b0;
        // Reset in WAIT of a store: response dropped, store kept.
        @(negedge clk);
        rv = 1'b1; wen = 1'b1; addr = 32'h80000020; wdata = 32'h55; wmask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rv = 1'b0; wen = 1'b0;
        chk("rst_in_wait_pre", {vld, rdy}, {1'b0, 1'b0});
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_wait", {rdy, vld, err, rdata}, {1'b1, 1'b0, 1'b0, 32'd0});
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_release_idle", {rdy, vld}, {1'b1, 1'b0});
        end
        mdl_store(32'h80000020, 32'h55, 4'hF);
        txn(1'b0, 32'h80000020, 32'h0, 4'h0, 0, rd, e, lat);
        chk("rst_store_kept", {e, rd}, {1'b0, 32'h55});
        // LATENCY=1 instance.
        sel = 1'b1;
        txn(1'b1, 32'h80000040, 32'h77, 4'hF, 1, rd, e, lat);
        chk("l1_store_latency", lat, 1);
        txn(1'b0, 32'h80000040, 32'h0, 4'h0, 0, rd, e, lat);
        chk("l1_load", {e, rd}, {1'b0, 32'h77});
        chk("l1_load_latency", lat, 1);
        @(negedge clk);
        rv = 1'b1; wen = 1'b1; addr = 32'h80000044; wdata = 32'h99; wmask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rv = 1'b0; wen = 1'b0;
        chk("l1_resp_before_reset", vld, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("l1_rst_in_resp", {rdy, vld, err, rdata}, {1'b1, 1'b0, 1'b0, 32'd0});
        reset = 1'b0;
        txn(1'b0, 32'h80000044, 32'h0, 4'h0, 0, rd, e, lat);
        chk("l1_store_kept", {e, rd}, {1'b0, 32'h99});
        sel = 1'b0;
        // Randomized traffic against the reference memory.
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 32'h80000FF8 + 32'($urandom_range(0, 3)) * 4;
            else a = 32'h7FFFFFF8 + 32'($urandom_range(0, 17)) * 4;
            a = a + 32'($urandom_range(0, 3));
            wdata = $urandom;
            txn(w, a, wdata, 4'($urandom_range(0, 15)), $urandom_range(0, 3), rd, e, lat);
            ee = !in_rng(a);
            er = '0;
            bm = '1;
            if (!w && !ee) begin
                if (mv.exists(widx(a))) begin
                    er = mv[widx(a)];
                    for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{mk[widx(a)][b]}};
                end else bm = '0;
            end
            chk($sformatf("rnd%0d_resp", i), {e, rd & bm}, {ee, er & bm});
            chk($sformatf("rnd%0d_latency", i), lat, 2);
            if (w) mdl_store(a, wdata, wmask);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
